// File: rtl/uart_rx.sv
// UART receiver: 2-flop rx synchroniser, oversampled start/data/parity/stop FSM,
// and a valid/ready holding register with frame, parity and overrun status.
//
// state  | meaning
// IDLE   | line idle; waits for rx_s low (after a framing error, first waits for rx_s high)
// START  | checks the start bit is still low at its centre
// DATA   | samples DATA_BITS data bits at their centres, LSB first
// PARITY | samples the parity bit and compares it with the data
// STOP   | samples the stop bit at its centre and completes the frame
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int SAMPLE     = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_sample,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(SAMPLE);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 rearm_q, rearm_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 done;
  logic                 done_fe;

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    rearm_d      = rearm_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    done         = 1'b0;
    done_fe      = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (en_sample) begin
      case (state_q)
        S_IDLE: begin
          // After a break the line must be seen high once before re-arming
          if (rearm_q) begin
            if (rx_s_q) rearm_d = 1'b0;
          end else if (!rx_s_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            idx_d = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d[idx_q] = rx_s_q;
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              par_err_d = 1'b0;
              state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_err_d = ((^shift_q) ^ rx_s_q) != ODD;
            cnt_d     = '0;
            state_d   = S_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            done    = 1'b1;
            done_fe = ~rx_s_q;
            rearm_d = ~rx_s_q;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A completion in the same cycle as an accept takes the holding register
    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        frame_err_d  = done_fe;
        parity_err_d = (PARITY_EN != 0) && par_err_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rearm_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      rearm_q      <= rearm_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance and an 8E1 instance share clock,
// reset and the 16x tick; monitors pop expected frames on every accepted output.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n, en_sample;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic       valid_b, fe_b, pe_b, ovr_b, busy_b;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad = 0;
  int   ovr_cnt_a = 0;
  int   ovr_cnt_b = 0;

  always #5 clk = ~clk;

  uart_rx #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en_sample(en_sample), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun_err(ovr_a), .rx_busy(busy_a));

  uart_rx #(.DATA_BITS(8), .SAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en_sample(en_sample), .rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun_err(ovr_b), .rx_busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One-clk tick every 4 clocks, driven just after the rising edge
  initial begin
    int div;
    div = 0;
    en_sample = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      en_sample = (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ovr_a === 1'b1) ovr_cnt_a++;
      if (valid_a === 1'b1 && ready_a === 1'b1) begin
        if (q_a.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_frame actual=%0h required=none", data_a);
        end else begin
          e = q_a.pop_front();
          chk("a_data", {24'd0, data_a}, {24'd0, e.d});
          chk("a_frame_err", {31'd0, fe_a}, {31'd0, e.fe});
          chk("a_parity_err", {31'd0, pe_a}, {31'd0, e.pe});
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ovr_b === 1'b1) ovr_cnt_b++;
      if (valid_b === 1'b1 && ready_b === 1'b1) begin
        if (q_b.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_frame actual=%0h required=none", data_b);
        end else begin
          e = q_b.pop_front();
          chk("b_data", {24'd0, data_b}, {24'd0, e.d});
          chk("b_frame_err", {31'd0, fe_b}, {31'd0, e.fe});
          chk("b_parity_err", {31'd0, pe_b}, {31'd0, e.pe});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_bit(input int which, input logic v);
    set_rx(which, v);
    idle(64);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                            input logic par, input logic stop);
    send_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(which, d[i]);
    if (has_par) send_bit(which, par);
    send_bit(which, stop);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_data"}, {24'd0, data_a}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, fe_a}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, pe_a}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, ovr_a}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    idle(3);
    reset_n = 1'b1;
    chk_idle_a("reset");
    chk("reset_b_valid", {31'd0, valid_b}, 32'd0);

    // 8N1 frame 0xA5
    q_a.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(64);
    chk("a5_no_overrun", ovr_cnt_a, 0);

    // Start-bit glitch: low for 4 ticks only
    set_rx(0, 1'b0);
    idle(12);
    chk("glitch_busy_high", {31'd0, busy_a}, 32'd1);
    idle(4);
    set_rx(0, 1'b1);
    idle(32);
    chk("glitch_busy_low", {31'd0, busy_a}, 32'd0);
    idle(32);
    q_a.push_back('{d: 8'h5A, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(64);

    // Framing error then break held for two frame times
    q_a.push_back('{d: 8'h3C, fe: 1'b1, pe: 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(640);
    chk("break_busy", {31'd0, busy_a}, 32'd0);
    chk("break_valid", {31'd0, valid_a}, 32'd0);
    idle(640);
    set_rx(0, 1'b1);
    idle(64);
    q_a.push_back('{d: 8'h01, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
    idle(64);

    // Even parity on the 8E1 instance: 0x07 has three ones
    q_b.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b0});
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(64);
    q_b.push_back('{d: 8'h07, fe: 1'b0, pe: 1'b1});
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(64);

    // Overrun: second frame lost while the first is held
    ready_a = 1'b0;
    q_a.push_back('{d: 8'h11, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(64);
    chk("overrun_pulses", ovr_cnt_a, 1);
    chk("overrun_held_valid", {31'd0, valid_a}, 32'd1);
    chk("overrun_held_data", {24'd0, data_a}, 32'h11);
    ready_a = 1'b1;
    idle(1);
    chk("accept_drops_valid", {31'd0, valid_a}, 32'd0);
    idle(64);

    // Reset in the middle of data bit 3 of 0xFF
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    set_rx(0, 1'b1);
    idle(32);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk_idle_a("midreset");
    idle(32 + 5 * 64);
    idle(64);
    q_a.push_back('{d: 8'h81, fe: 1'b0, pe: 1'b0});
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
    idle(64);

    chk("a_frames_left", q_a.size(), 0);
    chk("b_frames_left", q_b.size(), 0);
    chk("a_overrun_total", ovr_cnt_a, 1);
    chk("b_overrun_total", ovr_cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
